// File: rtl/hex_bcd_display_if.sv
// CPU write port and display outputs of the hex_bcd_display block.
// master = CPU side (drives writes), slave = the display converter.
interface hex_bcd_display_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        busy;
  logic        ovf;
  logic [31:0] bcd;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  modport master (
    output wr_en, wr_data,
    input  busy, ovf, bcd, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );

  modport slave (
    input  wr_en, wr_data,
    output busy, ovf, bcd, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );
endinterface

// File: rtl/hex_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving eight active-low
// 7-segment digits, with a one-deep pending write buffer and overflow dashes.
module hex_bcd_display #(
  parameter bit LZB   = 1'b1,
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  hex_bcd_display_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  localparam logic [31:0] OVF_LIMIT = 32'd100_000_000;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        bcd_q, bcd_d;
  logic [31:0]        pendData_q, pendData_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               ovfNext_q, ovfNext_d;
  logic               pend_q, pend_d;
  logic [6:0]         hex_q [8];
  logic [6:0]         hex_d [8];
  logic [6:0]         hexNew [8];
  logic [31:0]        adj;
  logic [WIDTH+31:0]  shifted;
  logic               leading;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Add-3 correction on every digit, then shift {acc, bin} left; top bit drops.
  always_comb begin
    adj = acc_q;
    for (int k = 0; k < 8; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;
  end

  // Segment image of the finished accumulator, scanned from the top digit down.
  always_comb begin
    leading = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      leading = leading && (acc_q[4*k +: 4] == 4'd0);
      if (ovfNext_q)                       hexNew[k] = 7'h3F;
      else if (LZB && leading && (k != 0)) hexNew[k] = 7'h7F;
      else                                 hexNew[k] = seg7(acc_q[4*k +: 4]);
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    bcd_d      = bcd_q;
    pendData_d = pendData_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    ovfNext_d  = ovfNext_q;
    pend_d     = pend_q;
    hex_d      = hex_q;

    if (bus.wr_en && (state_q != IDLE)) begin
      pend_d     = 1'b1;
      pendData_d = bus.wr_data;
    end

    case (state_q)
      IDLE: begin
        if (bus.wr_en || pend_q) begin
          bin_d     = bus.wr_en ? bus.wr_data : pendData_q;
          ovfNext_d = bus.wr_en ? (bus.wr_data >= OVF_LIMIT) : (pendData_q >= OVF_LIMIT);
          pend_d    = bus.wr_en ? pend_q : 1'b0;
          acc_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, bin_d} = shifted;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(WIDTH - 1)) state_d = LOAD;
      end
      LOAD: begin
        bcd_d = acc_q;
        ovf_d = ovfNext_q;
        hex_d = hexNew;
        // A queued value restarts immediately; a coinciding write becomes the new pending.
        if (pend_q) begin
          bin_d     = pendData_q;
          ovfNext_d = (pendData_q >= OVF_LIMIT);
          acc_d     = '0;
          cnt_d     = '0;
          if (!bus.wr_en) pend_d = 1'b0;
          state_d   = SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      acc_q      <= '0;
      bcd_q      <= '0;
      pendData_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovfNext_q  <= 1'b0;
      pend_q     <= 1'b0;
      for (int k = 0; k < 8; k++) hex_q[k] <= 7'h7F;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      bcd_q      <= bcd_d;
      pendData_q <= pendData_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      ovfNext_q  <= ovfNext_d;
      pend_q     <= pend_d;
      for (int k = 0; k < 8; k++) hex_q[k] <= hex_d[k];
    end
  end

  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;
  assign bus.bcd  = bcd_q;
  assign bus.HEX0 = hex_q[0];
  assign bus.HEX1 = hex_q[1];
  assign bus.HEX2 = hex_q[2];
  assign bus.HEX3 = hex_q[3];
  assign bus.HEX4 = hex_q[4];
  assign bus.HEX5 = hex_q[5];
  assign bus.HEX6 = hex_q[6];
  assign bus.HEX7 = hex_q[7];

endmodule

// File: tb/tb_hex_bcd_display.sv
// Scoreboard bench for hex_bcd_display: one instance with leading-zero blanking,
// one without, both fed the same writes; expectations are due at fixed edge counts.
module tb_hex_bcd_display;

  typedef struct {
    int          due;
    bit          all;
    bit          busy;
    logic [31:0] bcd;
    bit          ovf;
    logic [55:0] hexA;
    logic [55:0] hexB;
  } exp_t;

  localparam logic [55:0] H_BLANK   = {8{7'h7F}};
  localparam logic [55:0] H_DASH    = {8{7'h3F}};
  localparam logic [55:0] H_NINES   = {8{7'h10}};
  localparam logic [55:0] H_ZEROS   = {8{7'h40}};
  localparam logic [55:0] H123456_A = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [55:0] H123456_B = {7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [55:0] H0_A      = {{7{7'h7F}}, 7'h40};
  localparam logic [55:0] H5_A      = {{7{7'h7F}}, 7'h12};
  localparam logic [55:0] H5_B      = {{7{7'h40}}, 7'h12};
  localparam logic [55:0] H42_A     = {{6{7'h7F}}, 7'h19, 7'h24};
  localparam logic [55:0] H42_B     = {{6{7'h40}}, 7'h19, 7'h24};
  localparam logic [55:0] H1_A      = {{7{7'h7F}}, 7'h79};
  localparam logic [55:0] H1_B      = {{7{7'h40}}, 7'h79};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrEn;
  logic [31:0] wrData;
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        expQ[$];

  hex_bcd_display_if busA ();
  hex_bcd_display_if busB ();

  assign busA.wr_en   = wrEn;
  assign busA.wr_data = wrData;
  assign busB.wr_en   = wrEn;
  assign busB.wr_data = wrData;

  hex_bcd_display #(.LZB(1'b1), .WIDTH(32)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA.slave));
  hex_bcd_display #(.LZB(1'b0), .WIDTH(32)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic compareField(input string name, input logic [55:0] act, input logic [55:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("busyA", 56'(busA.busy), 56'(e.busy));
    compareField("busyB", 56'(busB.busy), 56'(e.busy));
    if (e.all) begin
      compareField("bcdA", 56'(busA.bcd), 56'(e.bcd));
      compareField("ovfA", 56'(busA.ovf), 56'(e.ovf));
      compareField("hexA", {busA.HEX7, busA.HEX6, busA.HEX5, busA.HEX4,
                            busA.HEX3, busA.HEX2, busA.HEX1, busA.HEX0}, e.hexA);
      compareField("bcdB", 56'(busB.bcd), 56'(e.bcd));
      compareField("ovfB", 56'(busB.ovf), 56'(e.ovf));
      compareField("hexB", {busB.HEX7, busB.HEX6, busB.HEX5, busB.HEX4,
                            busB.HEX3, busB.HEX2, busB.HEX1, busB.HEX0}, e.hexB);
    end
  endtask

  // Monitor: pops every expectation whose due edge has passed and compares it.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].due <= cycle) begin
      checkOutput(expQ.pop_front());
    end
  end

  task automatic pushExp(input int due, input bit all, input bit busy, input logic [31:0] bcd,
                         input bit ovf, input logic [55:0] hA, input logic [55:0] hB);
    exp_t e;
    e.due = due; e.all = all; e.busy = busy; e.bcd = bcd;
    e.ovf = ovf; e.hexA = hA; e.hexB = hB;
    expQ.push_back(e);
  endtask

  task automatic pushReset(input int due);
    pushExp(due, 1'b1, 1'b0, 32'h0, 1'b0, H_BLANK, H_BLANK);
  endtask

  task automatic waitTo(input int c);
    while (cycle < c) @(negedge clk);
  endtask

  // Called at a falling edge; e0 is the rising edge that samples the write.
  task automatic applyStimulus(input logic [31:0] v, output int e0);
    e0     = cycle + 1;
    wrData = v;
    wrEn   = 1'b1;
    @(negedge clk);
    wrEn   = 1'b0;
  endtask

  initial begin
    int e;
    int p;
    int guard;
    rst_n  = 1'b0;
    wrEn   = 1'b0;
    wrData = '0;
    pushReset(2);
    waitTo(2);
    rst_n = 1'b1;
    waitTo(3);

    applyStimulus(32'd123456, e);
    pushExp(e + 32, 1'b0, 1'b1, 32'h0, 1'b0, '0, '0);
    pushExp(e + 33, 1'b1, 1'b0, 32'h00123456, 1'b0, H123456_A, H123456_B);
    waitTo(e + 34);

    applyStimulus(32'd0, e);
    pushExp(e + 33, 1'b1, 1'b0, 32'h0, 1'b0, H0_A, H_ZEROS);
    waitTo(e + 34);

    applyStimulus(32'd99_999_999, e);
    pushExp(e + 33, 1'b1, 1'b0, 32'h99999999, 1'b0, H_NINES, H_NINES);
    waitTo(e + 34);
    applyStimulus(32'd100_000_000, e);
    pushExp(e + 33, 1'b1, 1'b0, 32'h00000000, 1'b1, H_DASH, H_DASH);
    waitTo(e + 34);

    applyStimulus(32'd5, e);
    pushExp(e + 33, 1'b1, 1'b1, 32'h5, 1'b0, H5_A, H5_B);
    pushExp(e + 34, 1'b0, 1'b1, 32'h0, 1'b0, '0, '0);
    pushExp(e + 50, 1'b1, 1'b1, 32'h5, 1'b0, H5_A, H5_B);
    waitTo(e + 10);
    applyStimulus(32'd7, p);
    waitTo(e + 12);
    applyStimulus(32'd42, p);
    pushExp(e + 66, 1'b1, 1'b0, 32'h42, 1'b0, H42_A, H42_B);
    waitTo(e + 67);

    applyStimulus(32'hFFFF_FFFF, e);
    pushExp(e + 33, 1'b1, 1'b0, 32'h94967295, 1'b1, H_DASH, H_DASH);
    waitTo(e + 34);
    applyStimulus(32'd1, e);
    pushExp(e + 33, 1'b1, 1'b0, 32'h1, 1'b0, H1_A, H1_B);
    waitTo(e + 34);

    applyStimulus(32'd123456, e);
    waitTo(e + 14);
    pushReset(e + 15);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pushReset(e + 33);
    pushReset(e + 40);
    waitTo(e + 41);

    guard = 0;
    while (expQ.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations still queued, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
